// File: rtl/pc_dbg_if.sv
// Fetch-PC generator bus: pipeline control, breakpoint programming and debug handshake.
// The master side drives requests; the slave side (pc_dbg_gen) returns PC and debug status.
interface pc_dbg_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NUM_BP  = 4,
    parameter int unsigned STALL_W = 6
);
    localparam int unsigned IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    logic [STALL_W-1:0] stall;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic               cp0_branch_flag;
    logic [ADDR_W-1:0]  cp0_branch_addr;
    logic               bp_wr_en;
    logic [IDX_W-1:0]   bp_wr_idx;
    logic [ADDR_W-1:0]  bp_wr_addr;
    logic               bp_wr_valid;
    logic               dbg_halt_req;
    logic               dbg_resume;
    logic               dbg_step;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               stop_o;
    logic               has_break;
    logic [IDX_W-1:0]   bp_hit_idx;
    logic [1:0]         dbg_state;

    modport master (
        output stall, branch_flag_i, branch_target_address_i, cp0_branch_flag, cp0_branch_addr,
               bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid, dbg_halt_req, dbg_resume, dbg_step,
        input  pc, ce, stop_o, has_break, bp_hit_idx, dbg_state
    );

    modport slave (
        input  stall, branch_flag_i, branch_target_address_i, cp0_branch_flag, cp0_branch_addr,
               bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid, dbg_halt_req, dbg_resume, dbg_step,
        output pc, ce, stop_o, has_break, bp_hit_idx, dbg_state
    );
endinterface

// File: rtl/pc_dbg_gen.sv
// MiniMIPS32 fetch PC generator: CP0 redirect > branch > sequential, with stall,
// programmable PC breakpoints and a RUN/HALT/STEP debug controller.
module pc_dbg_gen #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(32'hBFC00000),
    parameter int unsigned        PC_INC    = 4,
    parameter int unsigned        NUM_BP    = 4,
    parameter int unsigned        STALL_W   = 6
) (
    input  logic     clk,
    input  logic     rst,
    pc_dbg_if.slave  bus
);
    localparam int unsigned IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               ce_q, ce_d;
    logic [ADDR_W-1:0]  bp_addr_q [NUM_BP];
    logic [ADDR_W-1:0]  bp_addr_d [NUM_BP];
    logic [NUM_BP-1:0]  bp_valid_q, bp_valid_d;
    logic               bp_mask_q, bp_mask_d;
    logic               has_break_q, has_break_d;
    logic [IDX_W-1:0]   bp_hit_idx_q, bp_hit_idx_d;

    logic               bp_match_c;
    logic [IDX_W-1:0]   hit_idx_c;
    logic               hit_c;
    logic               adv_c;
    logic               pc_upd_c;
    logic               leave_halt_c;
    logic               unused_stall_c;

    // Breakpoint compare; descending scan so the lowest matching entry wins.
    always_comb begin
        bp_match_c = 1'b0;
        hit_idx_c  = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bp_valid_q[i] && (bp_addr_q[i] == pc_q)) begin
                bp_match_c = 1'b1;
                hit_idx_c  = IDX_W'(i);
            end
        end
        hit_c = ce_q && (state_q == ST_RUN) && !bp_mask_q && bp_match_c;
    end

    // Next-state, next-PC and breakpoint table update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ce_d          = 1'b1;
        bp_addr_d     = bp_addr_q;
        bp_valid_d    = bp_valid_q;
        bp_mask_d     = bp_mask_q;
        has_break_d   = 1'b0;
        bp_hit_idx_d  = bp_hit_idx_q;
        leave_halt_c  = 1'b0;

        adv_c    = ce_q && !bus.stall[0] &&
                   (((state_q == ST_RUN) && !hit_c && !bus.dbg_halt_req) || (state_q == ST_STEP));
        pc_upd_c = ce_q && (bus.cp0_branch_flag || adv_c);

        for (int i = 0; i < int'(NUM_BP); i++) begin
            if (bus.bp_wr_en && (bus.bp_wr_idx == IDX_W'(i))) begin
                bp_addr_d[i]  = bus.bp_wr_addr;
                bp_valid_d[i] = bus.bp_wr_valid;
            end
        end

        if (ce_q) begin
            if (bus.cp0_branch_flag) begin
                pc_d = bus.cp0_branch_addr;
            end else if (adv_c) begin
                pc_d = bus.branch_flag_i ? bus.branch_target_address_i : pc_q + ADDR_W'(PC_INC);
            end

            if (hit_c) begin
                has_break_d  = 1'b1;
                bp_hit_idx_d = hit_idx_c;
            end

            unique case (state_q)
                ST_RUN: begin
                    if (hit_c || bus.dbg_halt_req) state_d = ST_HALT;
                end
                ST_HALT: begin
                    if (bus.dbg_resume) begin
                        state_d      = ST_RUN;
                        leave_halt_c = 1'b1;
                    end else if (bus.dbg_step) begin
                        state_d      = ST_STEP;
                        leave_halt_c = 1'b1;
                    end
                end
                ST_STEP: begin
                    if (pc_upd_c) state_d = ST_HALT;
                end
                default: state_d = ST_RUN;
            endcase

            // Mask lets execution leave a breakpoint address it was halted on.
            if (pc_upd_c)     bp_mask_d = 1'b0;
            if (leave_halt_c) bp_mask_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_VEC;
            ce_q         <= 1'b0;
            bp_valid_q   <= '0;
            bp_mask_q    <= 1'b0;
            has_break_q  <= 1'b0;
            bp_hit_idx_q <= '0;
            for (int i = 0; i < int'(NUM_BP); i++) bp_addr_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            bp_valid_q   <= bp_valid_d;
            bp_mask_q    <= bp_mask_d;
            has_break_q  <= has_break_d;
            bp_hit_idx_q <= bp_hit_idx_d;
            bp_addr_q    <= bp_addr_d;
        end
    end

    assign unused_stall_c = ^bus.stall;

    assign bus.pc         = pc_q;
    assign bus.ce         = ce_q;
    assign bus.stop_o     = (state_q != ST_RUN) || hit_c || bus.dbg_halt_req;
    assign bus.has_break  = has_break_q;
    assign bus.bp_hit_idx = bp_hit_idx_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_pc_dbg_gen.sv
// Bench for pc_dbg_gen: directed fetch/breakpoint/debug scenarios plus randomized traffic
// checked against a cycle-level behavioural model; a 16-bit instance covers wrap and reset.
`timescale 1ns/1ps
module tb_pc_dbg_gen;
    localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_dbg_if #(.ADDR_W(32), .NUM_BP(4), .STALL_W(6)) bus_a ();
    pc_dbg_if #(.ADDR_W(16), .NUM_BP(4), .STALL_W(6)) bus_b ();

    pc_dbg_gen #(.ADDR_W(32), .RESET_VEC(32'hBFC00000), .PC_INC(4), .NUM_BP(4), .STALL_W(6))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    pc_dbg_gen #(.ADDR_W(16), .RESET_VEC(16'hFFFC), .PC_INC(4), .NUM_BP(4), .STALL_W(6))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    // Behavioural model of instance A
    logic [31:0] m_pc;
    bit          m_ce;
    int          m_mode;
    logic [31:0] m_bpa [4];
    bit          m_bpv [4];
    bit          m_mask;
    bit          m_hb;
    int          m_idx;

    task automatic model_reset();
        m_pc = RV; m_ce = 0; m_mode = M_RUN; m_mask = 0; m_hb = 0; m_idx = 0;
        for (int i = 0; i < 4; i++) begin m_bpa[i] = '0; m_bpv[i] = 0; end
    endtask

    function automatic int m_match();
        if (!m_ce || m_mode != M_RUN || m_mask) return -1;
        for (int i = 0; i < 4; i++) if (m_bpv[i] && m_bpa[i] == m_pc) return i;
        return -1;
    endfunction

    function automatic bit m_stop();
        return (m_mode != M_RUN) || (m_match() >= 0) || (bus_a.dbg_halt_req == 1'b1);
    endfunction

    task automatic model_step();
        int h;
        bit adv, moved, leave;
        if (!rst_a) begin model_reset(); return; end
        h = m_match();
        if (bus_a.bp_wr_en) begin
            m_bpa[int'(bus_a.bp_wr_idx)] = bus_a.bp_wr_addr;
            m_bpv[int'(bus_a.bp_wr_idx)] = bus_a.bp_wr_valid;
        end
        m_hb = 0;
        if (!m_ce) begin m_ce = 1; return; end
        adv = !bus_a.stall[0] &&
              ((m_mode == M_RUN && h < 0 && !bus_a.dbg_halt_req) || m_mode == M_STEP);
        moved = bus_a.cp0_branch_flag || adv;
        leave = 0;
        if (h >= 0) begin m_hb = 1; m_idx = h; end
        if (bus_a.cp0_branch_flag) m_pc = bus_a.cp0_branch_addr;
        else if (adv) m_pc = bus_a.branch_flag_i ? bus_a.branch_target_address_i : m_pc + 32'd4;
        case (m_mode)
            M_RUN:  if (h >= 0 || bus_a.dbg_halt_req) m_mode = M_HALT;
            M_HALT: if (bus_a.dbg_resume) begin m_mode = M_RUN; leave = 1; end
                    else if (bus_a.dbg_step) begin m_mode = M_STEP; leave = 1; end
            default: if (moved) m_mode = M_HALT;
        endcase
        if (moved) m_mask = 0;
        if (leave) m_mask = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_a();
        bus_a.stall = '0; bus_a.branch_flag_i = 0; bus_a.branch_target_address_i = '0;
        bus_a.cp0_branch_flag = 0; bus_a.cp0_branch_addr = '0; bus_a.bp_wr_en = 0;
        bus_a.bp_wr_idx = '0; bus_a.bp_wr_addr = '0; bus_a.bp_wr_valid = 0;
        bus_a.dbg_halt_req = 0; bus_a.dbg_resume = 0; bus_a.dbg_step = 0;
    endtask

    task automatic clear_b();
        bus_b.stall = '0; bus_b.branch_flag_i = 0; bus_b.branch_target_address_i = '0;
        bus_b.cp0_branch_flag = 0; bus_b.cp0_branch_addr = '0; bus_b.bp_wr_en = 0;
        bus_b.bp_wr_idx = '0; bus_b.bp_wr_addr = '0; bus_b.bp_wr_valid = 0;
        bus_b.dbg_halt_req = 0; bus_b.dbg_resume = 0; bus_b.dbg_step = 0;
    endtask

    task automatic test_reset();
        rst_a = 0; rst_b = 0;
        clear_a(); clear_b();
        model_reset();
        @(negedge clk);
        checks++; if (bus_a.pc !== RV) begin errors++; $display("FAIL reset_pc got %h want %h", bus_a.pc, RV); end
        checks++; if (bus_a.ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b want 0", bus_a.ce); end
        checks++; if (bus_a.dbg_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", bus_a.dbg_state); end
        checks++; if (bus_a.has_break !== 1'b0 || bus_a.bp_hit_idx !== 2'd0) begin errors++; $display("FAIL reset_break got %b/%0d want 0/0", bus_a.has_break, bus_a.bp_hit_idx); end
        checks++; if (bus_a.stop_o !== 1'b0) begin errors++; $display("FAIL reset_stop got %b want 0", bus_a.stop_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = RV; exp_pc[1] = RV + 32'd4; exp_pc[2] = RV + 32'd8;
        rst_a = 1;
        #1;
        checks++; if (bus_a.pc !== RV || bus_a.ce !== 1'b0) begin errors++; $display("FAIL seq_hold got %h/%b want %h/0", bus_a.pc, bus_a.ce, RV); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus_a.pc !== exp_pc[k] || bus_a.ce !== 1'b1) begin errors++; $display("FAIL seq_pc%0d got %h/%b want %h/1", k, bus_a.pc, bus_a.ce, exp_pc[k]); end
        end
    endtask

    task automatic test_stall_cp0();
        bus_a.stall = 6'b000001; bus_a.branch_flag_i = 1; bus_a.branch_target_address_i = 32'hBFC00100;
        tick();
        checks++; if (bus_a.pc !== RV + 32'd8) begin errors++; $display("FAIL stall_hold got %h want %h", bus_a.pc, RV + 32'd8); end
        bus_a.cp0_branch_flag = 1; bus_a.cp0_branch_addr = 32'hBFC00380;
        tick();
        checks++; if (bus_a.pc !== 32'hBFC00380) begin errors++; $display("FAIL cp0_redirect got %h want BFC00380", bus_a.pc); end
        clear_a();
        tick();
        checks++; if (bus_a.pc !== 32'hBFC00384) begin errors++; $display("FAIL after_cp0 got %h want BFC00384", bus_a.pc); end
    endtask

    task automatic test_breakpoint();
        rst_a = 0;
        #1;
        model_reset();
        checks++; if (bus_a.pc !== RV || bus_a.dbg_state !== 2'b00) begin errors++; $display("FAIL bp_rst got %h/%b want %h/00", bus_a.pc, bus_a.dbg_state, RV); end
        rst_a = 1;
        bus_a.bp_wr_en = 1; bus_a.bp_wr_idx = 2'd1; bus_a.bp_wr_addr = 32'hBFC00010; bus_a.bp_wr_valid = 1;
        tick();
        bus_a.bp_wr_idx = 2'd3;
        tick();
        bus_a.bp_wr_en = 0;
        for (int k = 0; k < 3; k++) tick();
        #1;
        checks++; if (bus_a.pc !== 32'hBFC00010 || bus_a.stop_o !== 1'b1) begin errors++; $display("FAIL bp_stop got %h/%b want BFC00010/1", bus_a.pc, bus_a.stop_o); end
        tick();
        checks++; if (bus_a.has_break !== 1'b1 || bus_a.bp_hit_idx !== 2'd1 || bus_a.dbg_state !== 2'b01) begin errors++; $display("FAIL bp_hit got hb=%b idx=%0d st=%b want 1/1/01", bus_a.has_break, bus_a.bp_hit_idx, bus_a.dbg_state); end
        tick();
        checks++; if (bus_a.has_break !== 1'b0 || bus_a.pc !== 32'hBFC00010) begin errors++; $display("FAIL bp_pulse got hb=%b pc=%h want 0/BFC00010", bus_a.has_break, bus_a.pc); end
    endtask

    task automatic test_step();
        bus_a.dbg_step = 1;
        tick();
        bus_a.dbg_step = 0;
        #1;
        checks++; if (bus_a.dbg_state !== 2'b10 || bus_a.stop_o !== 1'b1) begin errors++; $display("FAIL step_enter got %b/%b want 10/1", bus_a.dbg_state, bus_a.stop_o); end
        tick();
        checks++; if (bus_a.pc !== 32'hBFC00014 || bus_a.dbg_state !== 2'b01 || bus_a.has_break !== 1'b0) begin errors++; $display("FAIL step_done got %h/%b/%b want BFC00014/01/0", bus_a.pc, bus_a.dbg_state, bus_a.has_break); end
        bus_a.dbg_resume = 1;
        tick();
        bus_a.dbg_resume = 0;
        tick(); tick();
        checks++; if (bus_a.pc !== 32'hBFC0001C || bus_a.dbg_state !== 2'b00) begin errors++; $display("FAIL resume_run got %h/%b want BFC0001C/00", bus_a.pc, bus_a.dbg_state); end
    endtask

    task automatic test_rehit();
        bus_a.branch_flag_i = 1; bus_a.branch_target_address_i = 32'hBFC00010;
        tick();
        bus_a.branch_flag_i = 0;
        tick();
        checks++; if (bus_a.has_break !== 1'b1 || bus_a.dbg_state !== 2'b01) begin errors++; $display("FAIL rehit_halt got %b/%b want 1/01", bus_a.has_break, bus_a.dbg_state); end
        bus_a.dbg_resume = 1;
        tick();
        bus_a.dbg_resume = 0;
        #1;
        checks++; if (bus_a.stop_o !== 1'b0 || bus_a.pc !== 32'hBFC00010) begin errors++; $display("FAIL no_rehit got %b/%h want 0/BFC00010", bus_a.stop_o, bus_a.pc); end
        tick();
        checks++; if (bus_a.pc !== 32'hBFC00014 || bus_a.has_break !== 1'b0) begin errors++; $display("FAIL leave_bp got %h/%b want BFC00014/0", bus_a.pc, bus_a.has_break); end
        bus_a.branch_flag_i = 1;
        tick();
        bus_a.branch_flag_i = 0; bus_a.dbg_halt_req = 1;
        tick();
        bus_a.dbg_halt_req = 0;
        checks++; if (bus_a.has_break !== 1'b1 || bus_a.bp_hit_idx !== 2'd1 || bus_a.dbg_state !== 2'b01 || bus_a.pc !== 32'hBFC00010) begin errors++; $display("FAIL hit_and_halt got hb=%b idx=%0d st=%b pc=%h want 1/1/01/BFC00010", bus_a.has_break, bus_a.bp_hit_idx, bus_a.dbg_state, bus_a.pc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus_a.stall = 6'($urandom);
            bus_a.stall[0] = ($urandom_range(0, 3) == 0);
            bus_a.branch_flag_i = ($urandom_range(0, 3) == 0);
            bus_a.branch_target_address_i = RV + 32'(4 * $urandom_range(0, 15));
            bus_a.cp0_branch_flag = ($urandom_range(0, 31) == 0);
            bus_a.cp0_branch_addr = RV + 32'(4 * $urandom_range(0, 15));
            bus_a.dbg_halt_req = ($urandom_range(0, 15) == 0);
            bus_a.dbg_resume = ($urandom_range(0, 5) == 0);
            bus_a.dbg_step = ($urandom_range(0, 3) == 0);
            bus_a.bp_wr_en = ($urandom_range(0, 5) == 0);
            bus_a.bp_wr_idx = 2'($urandom);
            bus_a.bp_wr_addr = m_pc + 32'(4 * $urandom_range(1, 6));
            bus_a.bp_wr_valid = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (bus_a.stop_o !== m_stop()) begin errors++; $display("FAIL rnd%0d_stop got %b want %b", n, bus_a.stop_o, m_stop()); end
            tick();
            checks++; if (bus_a.pc !== m_pc) begin errors++; $display("FAIL rnd%0d_pc got %h want %h", n, bus_a.pc, m_pc); end
            checks++; if (bus_a.dbg_state !== 2'(m_mode) || bus_a.ce !== m_ce) begin errors++; $display("FAIL rnd%0d_state got %b/%b want %0d/%b", n, bus_a.dbg_state, bus_a.ce, m_mode, m_ce); end
            checks++; if (bus_a.has_break !== m_hb || bus_a.bp_hit_idx !== 2'(m_idx)) begin errors++; $display("FAIL rnd%0d_break got %b/%0d want %b/%0d", n, bus_a.has_break, bus_a.bp_hit_idx, m_hb, m_idx); end
        end
        clear_a();
    endtask

    task automatic test_wrap16();
        checks++; if (bus_b.pc !== 16'hFFFC || bus_b.ce !== 1'b0) begin errors++; $display("FAIL w16_reset got %h/%b want FFFC/0", bus_b.pc, bus_b.ce); end
        rst_b = 1;
        tick();
        checks++; if (bus_b.pc !== 16'hFFFC || bus_b.ce !== 1'b1) begin errors++; $display("FAIL w16_ce got %h/%b want FFFC/1", bus_b.pc, bus_b.ce); end
        tick();
        checks++; if (bus_b.pc !== 16'h0000) begin errors++; $display("FAIL w16_wrap got %h want 0000", bus_b.pc); end
        bus_b.dbg_halt_req = 1;
        tick();
        bus_b.dbg_halt_req = 0; bus_b.stall = 6'b000001; bus_b.dbg_step = 1;
        tick();
        bus_b.dbg_step = 0;
        tick();
        checks++; if (bus_b.dbg_state !== 2'b10 || bus_b.pc !== 16'h0000) begin errors++; $display("FAIL w16_step got %b/%h want 10/0000", bus_b.dbg_state, bus_b.pc); end
        #2;
        rst_b = 0;
        #1;
        checks++; if (bus_b.pc !== 16'hFFFC || bus_b.dbg_state !== 2'b00 || bus_b.ce !== 1'b0) begin errors++; $display("FAIL w16_async got %h/%b/%b want FFFC/00/0", bus_b.pc, bus_b.dbg_state, bus_b.ce); end
        clear_b();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_cp0();
        test_breakpoint();
        test_step();
        test_rehit();
        test_random();
        test_wrap16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
